// File: rtl/sha_digest_uart_tx.sv
// Serialises a latched digest over an 8N1/8N2 UART line, most significant byte first.
// Optional ASCII-hex output with trailing CR/LF when SHA_UART_HEX_EN is defined.
module sha_digest_uart_tx #(
  parameter int unsigned DIGEST_W     = 256,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGEST_W-1:0] i_digest,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_uart_tx,
  output logic                done
);

  localparam int unsigned NBYTES = DIGEST_W / 8;
`ifdef SHA_UART_HEX_EN
  localparam int unsigned NFRAMES = 2 * NBYTES + 2;
  localparam int unsigned SHIFT   = 4;
`else
  localparam int unsigned NFRAMES = NBYTES;
  localparam int unsigned SHIFT   = 8;
`endif
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W  = $clog2(NFRAMES + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NFRAMES - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state;
  logic [DIGEST_W-1:0] digest_sr;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_cnt;
  logic [IDX_W-1:0]    byte_idx;
  logic [7:0]          byte_sr;
  logic [7:0]          cur_char;
  logic                bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // The digest shifts left once per frame, so the next character always comes from the top bits.
`ifdef SHA_UART_HEX_EN
  logic [3:0] nib;
  always_comb begin
    nib      = digest_sr[DIGEST_W-1 -: 4];
    cur_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    if (byte_idx == IDX_W'(2 * NBYTES))
      cur_char = 8'h0D;
    else if (byte_idx > IDX_W'(2 * NBYTES))
      cur_char = 8'h0A;
  end
`else
  assign cur_char = digest_sr[DIGEST_W-1 -: 8];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      o_uart_tx <= 1'b1;
      o_busy    <= 1'b0;
      done      <= 1'b0;
      digest_sr <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      byte_sr   <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE)
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (i_start) begin
            digest_sr <= i_digest;
            byte_idx  <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            o_uart_tx <= 1'b0;
            o_busy    <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          if (bit_end) begin
            byte_sr   <= cur_char;
            o_uart_tx <= cur_char[0];
            bit_cnt   <= '0;
            state     <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              o_uart_tx <= 1'b1;
              bit_cnt   <= '0;
              state     <= STOP;
            end else begin
              o_uart_tx <= byte_sr[1];
              byte_sr   <= {1'b0, byte_sr[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end
        end

        STOP: begin
          // bit_cnt doubles as the stop-bit counter here
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              if (byte_idx == IDX_LAST) begin
                byte_idx <= '0;
                o_busy   <= 1'b0;
                done     <= 1'b1;
                state    <= IDLE;
              end else begin
                byte_idx  <= byte_idx + 1'b1;
                digest_sr <= digest_sr << SHIFT;
                o_uart_tx <= 1'b0;
                state     <= START;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
